// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state encoding and decode helpers for the alu_mc execute-stage ALU.
package alu_mc_pkg;

  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_SUB   = 5'h01;
  localparam logic [4:0] OP_AND   = 5'h02;
  localparam logic [4:0] OP_OR    = 5'h03;
  localparam logic [4:0] OP_NOR   = 5'h04;
  localparam logic [4:0] OP_XOR   = 5'h05;
  localparam logic [4:0] OP_SLT   = 5'h06;
  localparam logic [4:0] OP_SLL   = 5'h07;
  localparam logic [4:0] OP_SRL   = 5'h08;
  localparam logic [4:0] OP_SGT   = 5'h09;
  localparam logic [4:0] OP_SRA   = 5'h0A;
  localparam logic [4:0] OP_SLTU  = 5'h0B;
  localparam logic [4:0] OP_SGTU  = 5'h0C;
  localparam logic [4:0] OP_MUL   = 5'h10;
  localparam logic [4:0] OP_MULHU = 5'h11;
  localparam logic [4:0] OP_DIVU  = 5'h12;
  localparam logic [4:0] OP_REMU  = 5'h13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // MUL/MULHU/DIVU/REMU occupy 100xx.
  function automatic logic is_mdu_op(input logic [4:0] op_sel);
    return op_sel[4:2] == 3'b100;
  endfunction

endpackage

// File: rtl/alu_mc_mdu.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider sharing one
// accumulator, one step per cycle, DATA_WIDTH steps (the first taken on the start cycle).
module alu_mc_mdu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     hi_q, lo_q, m_q;
  logic             div_q;
  logic [W-1:0]     cur_hi, cur_lo, cur_m;
  logic             cur_div;
  logic [2*W-1:0]   nxt;

  // Multiply: {hi,lo} = {partial, multiplier}. Divide: hi = remainder, lo = dividend/quotient.
  function automatic logic [2*W-1:0] step(input logic div, input logic [W-1:0] h,
                                          input logic [W-1:0] l, input logic [W-1:0] m);
    logic [W:0] add_sum, shifted, trial;
    add_sum = {1'b0, h} + (l[0] ? {1'b0, m} : '0);
    shifted = {h, l[W-1]};
    trial   = shifted - {1'b0, m};
    if (!div)           return {add_sum, l[W-1:1]};
    else if (!trial[W]) return {trial[W-1:0], l[W-2:0], 1'b1};
    else                return {shifted[W-1:0], l[W-2:0], 1'b0};
  endfunction

  assign cur_div = start ? op : div_q;
  assign cur_hi  = start ? '0 : hi_q;
  assign cur_lo  = start ? (op ? a : b) : lo_q;
  assign cur_m   = start ? (op ? b : a) : m_q;
  assign nxt     = step(cur_div, cur_hi, cur_lo, cur_m);
  assign done    = (cnt == CNT_W'(DATA_WIDTH));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      {hi_q, lo_q} <= nxt;
      m_q          <= cur_m;
      div_q        <= op;
      cnt          <= CNT_W'(1);
    end else if (!done) begin
      {hi_q, lo_q} <= nxt;
      cnt          <= cnt + 1'b1;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign quotient  = lo_q;
  assign remainder = hi_q;

endmodule

// File: rtl/alu_mc.sv
// Handshaked execute-stage ALU with registered result and flags.
// Define ALU_MC_MDU_EN to build the iterative MUL/MULHU/DIVU/REMU unit.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 5,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [SEL_WIDTH-1:0]  opSel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  overflow,
  output logic                  illegal_op
);

`ifdef ALU_MC_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  localparam int MSB = DATA_WIDTH - 1;

  state_t                state, state_nxt;
  logic [31:0]           sel_ext;
  logic [4:0]            op;
  logic                  sel_in_range, op_mdu, accept;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] sum, diff, sc_res, mdu_res;
  logic                  sc_ovf, sc_legal, mdu_done;

  // Opcode bits above the 5-bit space must be zero for any legal operation.
  assign sel_ext      = 32'(opSel);
  assign op           = sel_ext[4:0];
  assign sel_in_range = (sel_ext[31:5] == '0);
  assign op_mdu       = MDU_EN && sel_in_range && is_mdu_op(op);
  assign accept       = in_valid && in_ready;

  assign shamt = operand2[SHAMT_W-1:0];
  assign sum   = operand1 + operand2;
  assign diff  = operand1 - operand2;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sc_res   = '0;
    sc_ovf   = 1'b0;
    sc_legal = sel_in_range;
    case (op)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (operand1[MSB] == operand2[MSB]) && (sum[MSB] != operand1[MSB]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (operand1[MSB] != operand2[MSB]) && (diff[MSB] != operand1[MSB]);
      end
      OP_AND:  sc_res = operand1 & operand2;
      OP_OR:   sc_res = operand1 | operand2;
      OP_NOR:  sc_res = ~(operand1 | operand2);
      OP_XOR:  sc_res = operand1 ^ operand2;
      OP_SLT:  sc_res = DATA_WIDTH'($signed(operand1) < $signed(operand2));
      OP_SGT:  sc_res = DATA_WIDTH'($signed(operand1) > $signed(operand2));
      OP_SLTU: sc_res = DATA_WIDTH'(operand1 < operand2);
      OP_SGTU: sc_res = DATA_WIDTH'(operand1 > operand2);
      OP_SLL:  sc_res = operand1 << shamt;
      OP_SRL:  sc_res = operand1 >> shamt;
      OP_SRA:  sc_res = $unsigned($signed(operand1) >>> shamt);
      default: sc_legal = 1'b0;
    endcase
    if (!sc_legal) begin
      sc_res = '0;
      sc_ovf = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = op_mdu ? ST_BUSY : ST_DONE;
      ST_BUSY: if (mdu_done) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = accept ? (op_mdu ? ST_BUSY : ST_DONE) : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    out_valid = (state == ST_DONE);
  end

`ifdef ALU_MC_MDU_EN
  logic [4:0]            mdu_op_q;
  logic [DATA_WIDTH-1:0] mdu_hi, mdu_lo, mdu_quo, mdu_rem;
  logic                  mdu_start;

  assign mdu_start = accept && op_mdu && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         mdu_op_q <= OP_MUL;
    else if (mdu_start) mdu_op_q <= op;
  end

  alu_mc_mdu #(.DATA_WIDTH(DATA_WIDTH)) u_mdu (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mdu_start),
    .op        (op[1]),
    .a         (operand1),
    .b         (operand2),
    .done      (mdu_done),
    .hi        (mdu_hi),
    .lo        (mdu_lo),
    .quotient  (mdu_quo),
    .remainder (mdu_rem)
  );

  always_comb begin
    case (mdu_op_q)
      OP_MUL:   mdu_res = mdu_lo;
      OP_MULHU: mdu_res = mdu_hi;
      OP_DIVU:  mdu_res = mdu_quo;
      OP_REMU:  mdu_res = mdu_rem;
      default:  mdu_res = '0;
    endcase
  end
`else
  assign mdu_done = 1'b0;
  assign mdu_res  = '0;
`endif

  // Output registers load only on a completion, so they hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      illegal_op <= 1'b0;
    end else if (!flush) begin
      if (accept && !op_mdu) begin
        result     <= sc_res;
        zero       <= (sc_res == '0);
        overflow   <= sc_ovf;
        illegal_op <= !sc_legal;
      end else if ((state == ST_BUSY) && mdu_done) begin
        result     <= mdu_res;
        zero       <= (mdu_res == '0);
        overflow   <= 1'b0;
        illegal_op <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, handshake corner sequences and
// randomized operations against an arithmetic reference model. Follows ALU_MC_MDU_EN.
module tb_alu_mc;

`ifdef ALU_MC_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif
  localparam int MDU_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, zero, overflow, illegal_op;
  logic [31:0] operand1, operand2, result;
  logic [4:0]  op_sel;

  int n_cmp = 0;
  int n_bad = 0;

  alu_mc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand1   (operand1),
    .operand2   (operand2),
    .opSel      (op_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          ovf;
    bit          ill;
    bit          mdu;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_mdu_code(input logic [4:0] op);
    return (op >= 5'd16) && (op <= 5'd19);
  endfunction

  // Reference model from the opcode table, using wide integer arithmetic.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output bit ovf, output bit ill);
    longint      s;
    logic [63:0] p;
    int          sh;
    res = '0; ovf = 1'b0; ill = 1'b0;
    sh  = int'(b[4:0]);
    p   = {32'b0, a} * {32'b0, b};
    case (op)
      5'd0: begin
        s = longint'($signed(a)) + longint'($signed(b));
        res = 32'(s);
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd1: begin
        s = longint'($signed(a)) - longint'($signed(b));
        res = 32'(s);
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd2:  res = a & b;
      5'd3:  res = a | b;
      5'd4:  res = ~(a | b);
      5'd5:  res = a ^ b;
      5'd6:  res = {31'b0, $signed(a) < $signed(b)};
      5'd7:  res = a << sh;
      5'd8:  res = a >> sh;
      5'd9:  res = {31'b0, $signed(a) > $signed(b)};
      5'd10: res = $unsigned($signed(a) >>> sh);
      5'd11: res = {31'b0, a < b};
      5'd12: res = {31'b0, a > b};
      5'd16: res = p[31:0];
      5'd17: res = p[63:32];
      5'd18: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd19: res = (b == 0) ? a : a % b;
      default: ill = 1'b1;
    endcase
    if (is_mdu_code(op) && !MDU_EN) begin
      res = '0;
      ill = 1'b1;
    end
  endfunction

  task automatic drive_accept(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_sel = op; operand1 = a; operand2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency counts clock edges from the accepting edge to the first one showing out_valid.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit ready_bad);
    drive_accept(op, a, b);
    lat = 1;
    ready_bad = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic run_checked(input string tag, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b);
    logic [31:0] e_res;
    bit          e_ovf, e_ill, rb;
    int          lat, e_lat;
    model(op, a, b, e_res, e_ovf, e_ill);
    e_lat = (is_mdu_code(op) && MDU_EN) ? MDU_LAT : 1;
    issue(op, a, b, lat, rb);
    check({tag, " result"}, result, e_res);
    check({tag, " zero"}, zero, e_res == 0);
    check({tag, " overflow"}, overflow, e_ovf);
    check({tag, " illegal"}, illegal_op, e_ill);
    check({tag, " latency"}, lat, e_lat);
  endtask

  initial begin
    vec_t        vecs[$];
    int          lat, e_lat;
    bit          rb, seen;
    logic [4:0]  codes[17] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                               5'd10, 5'd11, 5'd12, 5'd16, 5'd17, 5'd18, 5'd19};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_sel = '0; operand1 = '0; operand2 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset zero", zero, 0);
    check("reset overflow", overflow, 0);
    check("reset illegal_op", illegal_op, 0);
    @(negedge clk) rst_n = 1'b1;

    // op, a, b, expected result, overflow, illegal, is-MDU
    vecs.push_back('{5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{5'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{5'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{5'd10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{5'd8,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{5'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{5'd11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{5'd9,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{5'd12, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{5'd4,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{5'd31, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{5'd16, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{5'd17, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{5'd18, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 1'b1});
    vecs.push_back('{5'd19, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 1'b1});
    vecs.push_back('{5'd18, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{5'd19, 32'd7,         32'd0,         32'd7,         1'b0, 1'b0, 1'b1});
    vecs.push_back('{5'd16, 32'd3,         32'd4,         32'd12,        1'b0, 1'b0, 1'b1});

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      if (v.mdu && !MDU_EN) begin
        v.res = '0;
        v.ill = 1'b1;
      end
      e_lat = (v.mdu && MDU_EN) ? MDU_LAT : 1;
      issue(v.op, v.a, v.b, lat, rb);
      check($sformatf("vec%0d result", i), result, v.res);
      check($sformatf("vec%0d zero", i), zero, v.res == 0);
      check($sformatf("vec%0d overflow", i), overflow, v.ovf);
      check($sformatf("vec%0d illegal", i), illegal_op, v.ill);
      check($sformatf("vec%0d latency", i), lat, e_lat);
      check($sformatf("vec%0d in_ready_busy", i), rb, 0);
    end

    // Consumer stall: result held, no new accept.
    repeat (2) @(posedge clk);
    @(negedge clk) out_ready = 1'b0;
    issue(5'd0, 32'd2, 32'd3, lat, rb);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d result", i), result, 5);
      check($sformatf("hold%0d out_valid", i), out_valid, 1);
      check($sformatf("hold%0d in_ready", i), in_ready, 0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 check("hold release out_valid", out_valid, 0);

    // Back-to-back single-cycle ops at one per cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op_sel = 5'd0; operand1 = i; operand2 = 32'd10; in_valid = 1'b1;
      #1 check($sformatf("b2b%0d in_ready", i), in_ready, 1);
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d out_valid", i), out_valid, 1);
      check($sformatf("b2b%0d result", i), result, i + 10);
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);

    // Flush after accepting a MUL: back to IDLE, its result never appears.
    drive_accept(5'd16, 32'd3, 32'd4);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush out_valid", out_valid, 0);
    check("flush in_ready", in_ready, 1);
    @(negedge clk) flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check("flush no late result", seen, 0);

    // Flush with a simultaneous request drops the request.
    @(negedge clk);
    op_sel = 5'd0; operand1 = 32'd1; operand2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 check("flush+accept out_valid", out_valid, 0);
    @(negedge clk) begin in_valid = 1'b0; flush = 1'b0; end
    @(posedge clk);
    #1 check("flush+accept dropped", out_valid, 0);

    // Asynchronous reset in the middle of an MDU operation.
    run_checked("pre_reset", 5'd0, 32'd1, 32'd1);
    drive_accept(5'd16, 32'd3, 32'd4);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset result", result, 0);
    check("async reset in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    run_checked("post_reset add", 5'd0, 32'd7, 32'd8);
    run_checked("post_reset mul", 5'd16, 32'd3, 32'd4);

    // Randomized operations against the model.
    for (int i = 0; i < 200; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      int          pick;
      pick = $urandom_range(0, 19);
      op   = (pick < 17) ? codes[pick] : 5'($urandom_range(0, 31));
      a    = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = a;
        default: b = $urandom;
      endcase
      run_checked($sformatf("rnd%0d op%0d", i, op), op, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, handshaked successor to the execute-stage ALU of the pipeline processor. Accepts one operation per handshake and returns a registered result with zero, overflow and illegal-op flags. Single-cycle operations complete in 1 cycle; optional iterative multiply/divide operations complete in DATA_WIDTH+1 cycles. Sits in EX, between the ID/EX register and the EX/MEM register, which stalls on `in_ready`/`out_valid`.

## Interface
- DATA_WIDTH, 32: operand/result width; must be ≥ 8 and a power of two.
- SEL_WIDTH, 5: opcode width.
- SHAMT_W, $clog2(DATA_WIDTH): width of the shift amount taken from `operand2`.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous cancel of any in-flight or held operation.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- operand1  in  DATA_WIDTH  first operand.
- operand2  in  DATA_WIDTH  second operand; low SHAMT_W bits are the shift amount for shifts.
- opSel  in  SEL_WIDTH  opcode.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  DATA_WIDTH  registered result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow; ADD/SUB only, 0 otherwise.
- illegal_op  out  1  opcode unsupported; result forced to 0.

## Operation
- Opcodes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 NOR, 00101 XOR.
  - 00110 SLT (signed), 00111 SLL, 01000 SRL, 01001 SGT (signed).
  - 01010 SRA, 01011 SLTU, 01100 SGTU.
  - 10000 MUL (low half), 10001 MULHU (high half, unsigned).
  - 10010 DIVU, 10011 REMU.
  - All other codes are illegal.
- Comparisons return 1 or 0, zero-extended.
- Shift amount is `operand2[SHAMT_W-1:0]`; the decode stage extracts shamt.
- Arithmetic is modulo 2^DATA_WIDTH.
- Overflow:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from `operand1`.
- Divide by zero: DIVU = all ones, REMU = `operand1`; no flag.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → DONE on accept of a single-cycle or illegal op.
  - IDLE → BUSY on accept of an MDU op.
  - BUSY → DONE when the iteration counter reaches DATA_WIDTH.
  - DONE → IDLE on `out_ready` with no new accept.
  - DONE → DONE/BUSY on `out_ready` with a simultaneous accept (back-to-back).
- Handshake:
  - `in_ready` = IDLE, or DONE && `out_ready`.
  - Accept occurs when `in_valid && in_ready`.
  - `out_valid` = DONE.
  - result and flags are held stable while `out_valid && !out_ready`.
- Flush:
  - Forces IDLE at the next edge; an in-flight MDU result is discarded.
  - Takes priority over a simultaneous accept, which is dropped.
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, result 0, zero 0, overflow 0, illegal_op 0, iteration counter 0.
- Reset asserted mid-BUSY aborts the operation immediately (asynchronous).

## Timing
- Single-cycle op: accepted at edge N, `out_valid` high after edge N+1.
- MDU op: accepted at edge N, `in_ready` low through BUSY, `out_valid` high after edge N+DATA_WIDTH+1. DATA_WIDTH=32 gives 33 cycles.
- Maximum throughput for single-cycle ops is 1 per cycle while `out_ready` stays high.
- No combinational path from `in_valid`/operands to any output.
- Only `in_ready` depends combinationally on `out_ready`.

## Configuration
- `ALU_MC_MDU_EN` defined: MUL/MULHU/DIVU/REMU are implemented; the BUSY state and the iterative unit are built.
- Not defined: those four opcodes are illegal (result 0, `illegal_op` 1, 1-cycle latency). The BUSY state is unreachable and the iterative unit is not instantiated.

## Structure
- Package `alu_mc_pkg` holds:
  - the opcode localparams;
  - the FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - a function `is_mdu_op(opSel)`.
- Sub-module `alu_mc_mdu`, the iterative datapath:
  - shift-add multiplier producing 2×DATA_WIDTH bits;
  - restoring divider producing quotient and remainder;
  - interface: start, op, operands, done, hi, lo, quotient, remainder;
  - one iteration per cycle, DATA_WIDTH iterations.
- Parent holds the FSM, single-cycle datapath, flag logic and output registers.

## Test plan
- Reset: `rst_n` low mid-BUSY → `out_valid` 0, result 0, `in_ready` 1 immediately; the next op after release completes correctly.
- ADD 0x7FFFFFFF + 0x00000001 → 0x80000000, overflow 1, `out_valid` exactly 1 cycle after accept; SUB 5 − 5 → 0, zero 1.
- SRA 0x80000000 by 4 → 0xF8000000. SRL of the same → 0x08000000. SLT 0xFFFFFFFF vs 1 → 1; SLTU of the same → 0.
- MUL 0xFFFFFFFF × 2 → 0xFFFFFFFE; MULHU of the same → 0x00000001. `out_valid` exactly 33 cycles after accept, `in_ready` low throughout BUSY.
- DIVU 100/7 → 14, REMU → 2. DIVU 7/0 → 0xFFFFFFFF, REMU 7/0 → 7. Opcode 11111 → result 0, illegal_op 1.
- Hold `out_ready` low 5 cycles → result stable, `in_ready` low; flush during BUSY → IDLE next cycle, no `out_valid`. Without `ALU_MC_MDU_EN`: MUL 3×4 → result 0, illegal_op 1 after 1 cycle.
